// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: request/response
// bundles, FSM states, func3 encodings and access-decode functions.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] Wdata;
    logic [2:0]  func3;
    logic        Wmem;
    logic        Rmem;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] memOut;
    logic        respValid;
    logic        misaligned;
    logic        hold;
  } dmem_resp_t;

  // Unsupported encodings (including LBU/LHU used as a store size) are
  // rejected the same way as a misaligned access.
  function automatic logic access_misaligned(input logic [2:0] func3,
                                             input logic [1:0] addr_lo,
                                             input logic       is_store);
    logic bad;
    bad = 1'b1;
    case (func3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = addr_lo[0];
      F3_LW:   bad = |addr_lo;
      F3_LBU:  bad = is_store;
      F3_LHU:  bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (func3)
      F3_SB:   be = 4'b0001 << addr_lo;
      F3_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  func3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = wdata;
    case (func3)
      F3_SB:   lanes = {4{wdata[7:0]}};
      F3_SH:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// Selects the addressed byte/halfword lane of a memory word and applies
// sign or zero extension according to the load size.
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] memOut
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    memOut = 32'h0;
    case (func3)
      F3_LB:   memOut = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   memOut = {{16{half_lane[15]}}, half_lane};
      F3_LW:   memOut = word;
      F3_LBU:  memOut = {24'h0, byte_lane};
      F3_LHU:  memOut = {16'h0, half_lane};
      default: memOut = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: same-cycle byte-enabled stores, two-cycle loads
// through IDLE/READ/RESP with a pipeline hold while a load is in flight.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        Rmem,
  input  logic        Wmem,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic [2:0]  func3,
  output logic        hold,
  output logic        respValid,
  output logic [31:0] memOut,
  output logic        misaligned
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_req_t   req;
  dmem_resp_t  resp;
  dmem_state_t state_q, state_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      read_word_q;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       be;
  logic [31:0]      wdata_lanes;
  logic             is_store, is_load, access_bad, idle;
  logic             store_go, load_go, mis_event;
  logic             mis_q, load_bad_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       func3_q;
  logic [31:0]      mem_out_q;
  logic [31:0]      aligned_word;
  logic             unused_addr_bits;

  assign req = '{addr: addr, Wdata: Wdata, func3: func3, Wmem: Wmem, Rmem: Rmem};

  assign word_idx         = req.addr[IDX_W+1:2];
  assign unused_addr_bits = ^req.addr[31:IDX_W+2];

  // A simultaneous Wmem/Rmem request is a store; the read is dropped.
  assign is_store    = req.Wmem;
  assign is_load     = req.Rmem & ~req.Wmem;
  assign access_bad  = access_misaligned(req.func3, req.addr[1:0], is_store);
  assign idle        = (state_q == ST_IDLE);
  assign store_go    = nReset & idle & is_store & ~access_bad;
  assign load_go     = nReset & idle & is_load;
  assign mis_event   = nReset & idle & (is_store | is_load) & access_bad;
  assign be          = store_be(req.func3, req.addr[1:0]);
  assign wdata_lanes = store_lanes(req.func3, req.Wdata);

  // Array contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (store_go) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
    if (load_go) read_word_q <= mem[word_idx];
  end

  dmem_load_align u_align (
    .word    (read_word_q),
    .addr_lo (addr_lo_q),
    .func3   (func3_q),
    .memOut  (aligned_word)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      mis_q      <= 1'b0;
      load_bad_q <= 1'b0;
      addr_lo_q  <= 2'b00;
      func3_q    <= 3'b000;
      mem_out_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      mis_q   <= mis_event;
      if (load_go) begin
        load_bad_q <= access_bad;
        addr_lo_q  <= req.addr[1:0];
        func3_q    <= req.func3;
      end
      // memOut is loaded once on entry to RESP and then held.
      if (state_q == ST_READ) mem_out_q <= load_bad_q ? 32'h0 : aligned_word;
    end
  end

  always_comb begin
    state_d         = state_q;
    resp.hold       = 1'b0;
    resp.respValid  = 1'b0;
    resp.misaligned = mis_q;
    resp.memOut     = mem_out_q;
    case (state_q)
      ST_IDLE: begin
        if (load_go) begin
          state_d   = ST_READ;
          resp.hold = 1'b1;
        end
      end
      ST_READ: begin
        state_d   = ST_RESP;
        resp.hold = 1'b1;
      end
      ST_RESP: begin
        state_d        = ST_IDLE;
        resp.respValid = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hold       = resp.hold;
  assign respValid  = resp.respValid;
  assign misaligned = resp.misaligned;
  assign memOut     = resp.memOut;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic compared against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        clk;
  logic        nReset;
  logic        Rmem;
  logic        Wmem;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic [2:0]  func3;
  logic        hold;
  logic        respValid;
  logic [31:0] memOut;
  logic        misaligned;

  int tests;
  int failures;
  logic [7:0]  modelMem [BYTES];
  logic [31:0] lastOut;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .Rmem       (Rmem),
    .Wmem       (Wmem),
    .addr       (addr),
    .Wdata      (Wdata),
    .func3      (func3),
    .hold       (hold),
    .respValid  (respValid),
    .memOut     (memOut),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelBad(input logic [2:0] f3, input logic [31:0] a, input bit isStore);
    int off;
    off = int'(a % 4);
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return (off % 2) != 0;
      3'd2:    return off != 0;
      3'd4:    return isStore;
      3'd5:    return isStore || ((off % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] f3);
    int b;
    logic [7:0]  b0;
    logic [15:0] h;
    b  = int'(a % BYTES);
    b0 = modelMem[b];
    case (f3)
      3'd0: return (b0 >= 8'h80) ? 32'hFFFF_FF00 + b0 : {24'h0, b0};
      3'd4: return {24'h0, b0};
      3'd1, 3'd5: begin
        h = {modelMem[b+1], modelMem[b]};
        if (f3 == 3'd1 && h >= 16'h8000) return 32'hFFFF_0000 + h;
        return {16'h0, h};
      end
      3'd2: return {modelMem[b+3], modelMem[b+2], modelMem[b+1], modelMem[b]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int b;
    int n;
    b = int'(a % BYTES);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) modelMem[b+i] = d[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete request, from acceptance through the end of any response.
  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f3);
    bit isStore;
    bit isLoad;
    bit bad;
    logic [31:0] expOut;
    isStore = w;
    isLoad  = r && !w;
    bad     = (isStore || isLoad) && modelBad(f3, a, isStore);
    expOut  = bad ? 32'h0 : modelLoad(a, f3);
    @(negedge clk);
    Rmem = r; Wmem = w; addr = a; Wdata = d; func3 = f3;
    #1;
    checkOutput("hold_accept", hold, {31'h0, isLoad});
    checkOutput("resp_accept", respValid, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mis_pulse", misaligned, {31'h0, bad});
    checkOutput("hold_c1", hold, {31'h0, isLoad});
    checkOutput("resp_c1", respValid, 32'h0);
    Rmem = 1'b0; Wmem = 1'b0;
    addr = $urandom; Wdata = $urandom; func3 = 3'($urandom_range(0, 7));
    if (isStore && !bad) modelStore(a, d, f3);
    if (isLoad) begin
      @(posedge clk);
      #1;
      checkOutput("resp_valid", respValid, 32'h1);
      checkOutput("hold_resp", hold, 32'h0);
      checkOutput("mis_resp", misaligned, 32'h0);
      checkOutput("mem_out", memOut, expOut);
      lastOut = expOut;
      @(posedge clk);
      #1;
      checkOutput("resp_after", respValid, 32'h0);
      checkOutput("mem_out_held", memOut, lastOut);
    end else begin
      @(posedge clk);
      #1;
      checkOutput("mis_after", misaligned, 32'h0);
      checkOutput("resp_none", respValid, 32'h0);
      checkOutput("mem_out_idle", memOut, lastOut);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    lastOut  = 32'h0;
    nReset   = 1'b0;
    Rmem     = 1'b1;
    Wmem     = 1'b0;
    addr     = 32'h0;
    Wdata    = 32'h0;
    func3    = 3'd2;

    // Reset with a pending load request: outputs stay quiet.
    #2;
    checkOutput("rst_hold", hold, 32'h0);
    checkOutput("rst_resp", respValid, 32'h0);
    checkOutput("rst_mis", misaligned, 32'h0);
    checkOutput("rst_out", memOut, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    Rmem   = 1'b0;
    nReset = 1'b1;

    // Fill the whole array so every later load has defined data.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, 3'd2);

    // Word store/load round trip.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    checkOutput("lw_deadbeef", lastOut, 32'hDEAD_BEEF);

    // Byte store, signed/unsigned byte loads, neighbours intact.
    applyStimulus(1'b0, 1'b1, 32'h13, 32'h80, 3'd0);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 3'd0);
    checkOutput("lb_sext", lastOut, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 3'd4);
    checkOutput("lbu_zext", lastOut, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    checkOutput("sb_neighbours", lastOut, 32'h80AD_BEEF);

    // Misaligned halfword load and word store.
    applyStimulus(1'b1, 1'b0, 32'h11, 32'h0, 3'd1);
    applyStimulus(1'b0, 1'b1, 32'h12, 32'h1111_2222, 3'd2);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    checkOutput("sw_mis_nowrite", lastOut, 32'h80AD_BEEF);

    // Halfword lanes and unsupported func3.
    applyStimulus(1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
    checkOutput("lh_upper", lastOut, 32'hFFFF_80AD);
    applyStimulus(1'b1, 1'b0, 32'h12, 32'h0, 3'd5);
    checkOutput("lhu_upper", lastOut, 32'h0000_80AD);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3'd3);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h5555_5555, 3'd6);

    // Address wrap-around beyond the array.
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h1234_5678, 3'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
    checkOutput("wrap_lw", lastOut, 32'h1234_5678);

    // Simultaneous Wmem/Rmem behaves as a store.
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 3'd2);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
    checkOutput("both_store", lastOut, 32'hA5A5_A5A5);

    // Reset while a load sits in READ aborts it.
    @(negedge clk);
    Rmem = 1'b1; addr = 32'h10; func3 = 3'd2;
    #1;
    checkOutput("abort_accept_hold", hold, 32'h1);
    @(posedge clk);
    #1;
    Rmem   = 1'b0;
    nReset = 1'b0;
    #1;
    checkOutput("abort_hold", hold, 32'h0);
    checkOutput("abort_resp", respValid, 32'h0);
    checkOutput("abort_out", memOut, 32'h0);
    lastOut = 32'h0;
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_resp", respValid, 32'h0);
      checkOutput("abort_no_hold", hold, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    checkOutput("after_abort_lw", lastOut, 32'h80AD_BEEF);

    // Random traffic against the reference memory.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      int rw;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      rw = $urandom_range(0, 3);
      applyStimulus(rw[0], rw[1], ra, $urandom, 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit data memory words (power of two).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port nReset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port Rmem, input, 1 bit, load request from the MEM stage.
REQ-005 The module SHALL have port Wmem, input, 1 bit, store request from the MEM stage.
REQ-006 The module SHALL have port addr, input, 32 bits, byte address (the EXE result).
REQ-007 The module SHALL have port Wdata, input, 32 bits, store data (the EXE rs2).
REQ-008 The module SHALL have port func3, input, 3 bits, access size and sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 The module SHALL have port hold, output, 1 bit, stall request to the pipeline while a load is in flight.
REQ-010 The module SHALL have port respValid, output, 1 bit, one-cycle pulse marking valid memOut.
REQ-011 The module SHALL have port memOut, output, 32 bits, aligned and extended load data.
REQ-012 The module SHALL have port misaligned, output, 1 bit, one-cycle pulse flagging a rejected misaligned access.

Function
REQ-013 FSM states SHALL be IDLE, READ, RESP; requests SHALL be sampled only in IDLE, and inputs in READ/RESP SHALL be ignored.
REQ-014 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, giving wrap-around.
REQ-015 Misaligned SHALL mean a halfword access with addr[0]=1, or a word access with addr[1:0]!=00; byte accesses are never misaligned.
REQ-016 An aligned store in IDLE SHALL write in the same cycle using byte enables from func3/addr[1:0], with Wdata lanes replicated as per RV32I; hold stays 0, state stays IDLE, respValid stays 0.
REQ-017 An aligned load in IDLE SHALL assert hold combinationally that cycle, register the array read, go to READ, then RESP.
REQ-018 In RESP, respValid SHALL be 1, memOut SHALL be valid and hold SHALL be 0, then the state returns to IDLE; load latency is 2 cycles from acceptance to respValid.
REQ-019 hold SHALL be 1 in the acceptance cycle and in READ.
REQ-020 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the full word; byte and halfword lanes are selected by addr[1:0].
REQ-021 On a misaligned access, no array write SHALL occur, misaligned SHALL pulse for one cycle next cycle, and a load SHALL still complete via READ/RESP with memOut=0.
REQ-022 If Wmem and Rmem are both 1, the request SHALL be treated as a store and Rmem ignored.
REQ-023 An unsupported func3 (011, 110, 111) SHALL be treated as misaligned.
REQ-024 memOut SHALL hold its last value outside RESP; respValid and misaligned SHALL be 0 outside their pulse cycles.

Reset
REQ-025 While nReset=0, the state SHALL be IDLE and hold, respValid, misaligned and memOut SHALL be 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset during READ or RESP SHALL abort the load with no respValid after release.

Structure
REQ-028 The shared types package SHALL gain dmem_req_t {addr, Wdata, func3, Wmem, Rmem}, dmem_resp_t {memOut, respValid, misaligned, hold}, enum dmem_state_t, and func3 load/store constants.
REQ-029 The module SHALL contain one combinational sub-module, dmem_load_align (word, addr[1:0], func3 -> memOut), reused by the bench model.

Verification
REQ-030 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> hold high for 2 cycles, respValid in cycle 3, memOut=0xDEADBEEF.
REQ-031 SB 0x13 data=0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; other bytes of word 0x10 unchanged.
REQ-032 LH addr=0x11 -> misaligned pulse, memOut=0; SW addr=0x12 -> no write (a following LW 0x10 returns the prior value).
REQ-033 With DEPTH_WORDS=1024, SW 0x1000 data=0x12345678 then LW 0x0 -> 0x12345678 (wrap-around).
REQ-034 nReset low in READ -> no respValid, hold=0, IDLE; a following LW completes normally.
REQ-035 Wmem=Rmem=1 SW-style at 0x20 data=0xA5A5A5A5 -> hold stays 0, no respValid; LW 0x20 -> 0xA5A5A5A5.
